// File: rtl/theta_chunk_sched_if.sv
// Signal bundle between theta_chunk_sched (master) and its load / datapath / unload side (slave).
// round_idx and last_round exist only when ROUND_IDX_OUT_EN is defined.
interface theta_chunk_sched_if;
   logic          load_valid;
   logic          load_ready;
   logic [0:199]  load_data;
   logic          chunk_valid;
   logic [2:0]    chunk_idx;
   logic [0:199]  chunk_out;
   logic [0:24]   pre_out;
   logic          ret_valid;
   logic [0:199]  ret_data;
   logic          out_valid;
   logic          out_ready;
   logic [0:199]  out_data;
   logic          busy;
   logic          err_timeout;
`ifdef ROUND_IDX_OUT_EN
   logic [4:0]    round_idx;
   logic          last_round;

   modport master (
      input  load_valid, load_data, ret_valid, ret_data, out_ready,
      output load_ready, chunk_valid, chunk_idx, chunk_out, pre_out,
             out_valid, out_data, busy, err_timeout, round_idx, last_round
   );
   modport slave (
      output load_valid, load_data, ret_valid, ret_data, out_ready,
      input  load_ready, chunk_valid, chunk_idx, chunk_out, pre_out,
             out_valid, out_data, busy, err_timeout, round_idx, last_round
   );
`else
   modport master (
      input  load_valid, load_data, ret_valid, ret_data, out_ready,
      output load_ready, chunk_valid, chunk_idx, chunk_out, pre_out,
             out_valid, out_data, busy, err_timeout
   );
   modport slave (
      output load_valid, load_data, ret_valid, ret_data, out_ready,
      input  load_ready, chunk_valid, chunk_idx, chunk_out, pre_out,
             out_valid, out_data, busy, err_timeout
   );
`endif
endinterface

// File: rtl/theta_chunk_sched.sv
// Slice-serial Keccak-f[1600] state scheduler feeding theta: load, per-round chunk issue/return, unload.
// Define ROUND_IDX_OUT_EN to add the round_idx / last_round outputs.
module theta_chunk_sched #(
   parameter int ROUNDS  = 24,
   parameter int LAT_MAX = 15
) (
   input  logic                clk,
   input  logic                rst,
   theta_chunk_sched_if.master bus
);
   localparam int              WD_LIM   = LAT_MAX + 8;
   localparam int              WD_W     = $clog2(WD_LIM + 1);
   localparam logic [4:0]      LAST_RND = 5'(ROUNDS - 1);
   localparam logic [WD_W-1:0] WD_END   = WD_W'(WD_LIM - 1);

   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, UNLOAD} state_t;

   state_t          st;
   logic [0:199]    mem [8];
   logic [2:0]      ld_cnt, iss_cnt, ret_cnt, ul_cnt;
   logic [4:0]      rnd;
   logic [WD_W-1:0] wd_cnt;
   logic [0:24]     snap;
   logic            load_hs, ret_hs, out_hs, last_ret;

   function automatic logic [0:24] first_slice(input logic [0:199] c);
      logic [0:24] s;
      s = '0;
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            s[5*y + x] = c[40*y + 8*x];
      return s;
   endfunction

   assign load_hs  = bus.load_valid & bus.load_ready;
   assign ret_hs   = bus.ret_valid & ((st == ISSUE) | (st == WAIT));
   assign out_hs   = bus.out_valid & bus.out_ready;
   assign last_ret = ret_hs & (st == WAIT) & (ret_cnt == 3'd7);

   // State RAM is never cleared; loads and returns cannot occur in the same state
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (load_hs)     mem[ld_cnt]  <= bus.load_data;
         else if (ret_hs) mem[ret_cnt] <= bus.ret_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st              <= IDLE;
         ld_cnt          <= 3'd0;
         iss_cnt         <= 3'd0;
         ret_cnt         <= 3'd0;
         ul_cnt          <= 3'd0;
         rnd             <= 5'd0;
         wd_cnt          <= '0;
         bus.load_ready  <= 1'b0;
         bus.chunk_valid <= 1'b0;
         bus.chunk_idx   <= 3'd0;
         bus.chunk_out   <= '0;
         bus.pre_out     <= '0;
         bus.out_valid   <= 1'b0;
         bus.out_data    <= '0;
         bus.busy        <= 1'b0;
         bus.err_timeout <= 1'b0;
`ifdef ROUND_IDX_OUT_EN
         bus.round_idx   <= 5'd0;
         bus.last_round  <= 1'b0;
`endif
      end else begin
         bus.chunk_valid <= 1'b0;
         if (ret_hs) ret_cnt <= ret_cnt + 3'd1;
         unique case (st)
            IDLE: begin
               bus.load_ready <= 1'b1;
               if (load_hs) begin
                  st       <= LOAD;
                  ld_cnt   <= 3'd1;
                  bus.busy <= 1'b1;
               end
            end
            LOAD: begin
               if (load_hs) begin
                  ld_cnt <= ld_cnt + 3'd1;
                  if (ld_cnt == 3'd7) begin
                     st             <= ISSUE;
                     rnd            <= 5'd0;
                     iss_cnt        <= 3'd0;
                     ret_cnt        <= 3'd0;
                     bus.load_ready <= 1'b0;
                  end
               end
            end
            ISSUE: begin
               // chunk 0 is snapshotted here so its early write-back cannot leak into chunk 7's pre_out
               bus.chunk_valid <= 1'b1;
               bus.chunk_idx   <= iss_cnt;
               bus.chunk_out   <= mem[iss_cnt];
               bus.pre_out     <= (iss_cnt == 3'd7) ? snap : first_slice(mem[iss_cnt + 3'd1]);
               if (iss_cnt == 3'd0) snap <= first_slice(mem[0]);
`ifdef ROUND_IDX_OUT_EN
               bus.round_idx   <= rnd;
               bus.last_round  <= (rnd == LAST_RND);
`endif
               iss_cnt <= iss_cnt + 3'd1;
               wd_cnt  <= '0;
               if (iss_cnt == 3'd7) st <= WAIT;
            end
            WAIT: begin
               if (last_ret) begin
                  wd_cnt <= '0;
                  if (rnd == LAST_RND) begin
                     st            <= UNLOAD;
                     ul_cnt        <= 3'd0;
                     bus.out_valid <= 1'b1;
                     bus.out_data  <= mem[0];
                  end else begin
                     rnd <= rnd + 5'd1;
                     st  <= ISSUE;
                  end
               end else if (ret_hs) begin
                  wd_cnt <= '0;
               end else if (wd_cnt == WD_END) begin
                  bus.err_timeout <= 1'b1;
                  bus.busy        <= 1'b0;
                  bus.load_ready  <= 1'b1;
                  ld_cnt          <= 3'd0;
                  st              <= IDLE;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
            end
            UNLOAD: begin
               if (out_hs) begin
                  ul_cnt       <= ul_cnt + 3'd1;
                  bus.out_data <= mem[ul_cnt + 3'd1];
                  if (ul_cnt == 3'd7) begin
                     bus.out_valid  <= 1'b0;
                     bus.busy       <= 1'b0;
                     bus.load_ready <= 1'b1;
                     ld_cnt         <= 3'd0;
                     st             <= IDLE;
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule
